// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: FSM states, memory op and access size,
// plus the store-side strobe and data replication helpers.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } memState_t;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    function automatic logic [3:0] calcWstrb(input logic [1:0] size, input logic [1:0] addrLo);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << addrLo;
            SIZE_HALF: strb = addrLo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: strb = 4'b1111;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate the store data across all lanes so the strobes alone pick the bytes.
    function automatic logic [31:0] calcWdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wdata;
        case (size)
            SIZE_BYTE: wdata = {4{data[7:0]}};
            SIZE_HALF: wdata = {2{data[15:0]}};
            default:   wdata = data;
        endcase
        return wdata;
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data alignment and extension: picks the addressed byte/half out of the
// read word and sign- or zero-extends it to 32 bits.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_result = i_rdata;
        case (i_size)
            SIZE_BYTE: o_result = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_result = {{16{i_signed & w_half[15]}}, w_half};
            default:   o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: latches the EX payload, runs one data-SRAM handshake for
// loads/stores and presents the finished result to the WB register.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        i_ex_to_mem_valid,
    output logic        o_mem_allowin,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_alu_result,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_rf_we,
    input  logic [1:0]  i_ex_mem_op,
    input  logic [1:0]  i_ex_mem_size,
    input  logic        i_ex_load_signed,
    input  logic [31:0] i_ex_store_data,

    output logic        o_data_req,
    output logic        o_data_wr,
    output logic [1:0]  o_data_size,
    output logic [31:0] o_data_addr,
    output logic [3:0]  o_data_wstrb,
    output logic [31:0] o_data_wdata,
    input  logic        i_data_addr_ok,
    input  logic        i_data_data_ok,
    input  logic [31:0] i_data_rdata,

    input  logic        i_wb_allowin,
    output logic        o_mem_ready_go,
    output logic [31:0] o_mem_pc,
    output logic [4:0]  o_mem_rd,
    output logic        o_mem_rf_we,
    output logic [31:0] o_mem_result,
    output logic        o_mem_fwd_busy
);

    memState_t   r_state;
    memState_t   w_nextState;

    logic [31:0] r_pc;
    logic [31:0] r_aluResult;
    logic [4:0]  r_rd;
    logic        r_rfWe;
    logic [1:0]  r_memOp;
    logic [1:0]  r_memSize;
    logic        r_loadSigned;
    logic [31:0] r_storeData;
    logic [31:0] r_rdata;

    logic        w_capture;
    logic        w_exIsMem;
    logic        w_isLoad;
    logic        w_rdataCapture;
    logic [31:0] w_loadResult;

    // Op code 11 falls through as a plain ALU instruction.
    assign w_exIsMem = (i_ex_mem_op == MEM_OP_LOAD) || (i_ex_mem_op == MEM_OP_STORE);
    assign w_isLoad  = (r_memOp == MEM_OP_LOAD);
    assign w_capture = i_ex_to_mem_valid && o_mem_allowin;

    assign w_rdataCapture = ((r_state == ST_REQ) && i_data_addr_ok && i_data_data_ok) ||
                            ((r_state == ST_WAIT) && i_data_data_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_nextState = w_exIsMem ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (i_data_addr_ok) begin
                    w_nextState = i_data_data_ok ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_data_data_ok) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_capture) begin
                    w_nextState = w_exIsMem ? ST_REQ : ST_DONE;
                end else if (i_wb_allowin) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // The request is masked by rst directly so the shared SRAM never sees it during reset.
    always_comb begin
        o_mem_allowin  = 1'b0;
        o_data_req     = 1'b0;
        o_mem_ready_go = 1'b0;
        o_mem_fwd_busy = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_mem_allowin = 1'b1;
            end
            ST_REQ: begin
                o_data_req     = !rst;
                o_mem_fwd_busy = w_isLoad && r_rfWe;
            end
            ST_WAIT: begin
                o_mem_fwd_busy = w_isLoad && r_rfWe;
            end
            ST_DONE: begin
                o_mem_ready_go = 1'b1;
                o_mem_allowin  = i_wb_allowin;
            end
            default: begin
                o_mem_allowin = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= 32'h0;
            r_aluResult  <= 32'h0;
            r_rd         <= 5'h0;
            r_rfWe       <= 1'b0;
            r_memOp      <= MEM_OP_NONE;
            r_memSize    <= SIZE_BYTE;
            r_loadSigned <= 1'b0;
            r_storeData  <= 32'h0;
        end else if (w_capture) begin
            r_pc         <= i_ex_pc;
            r_aluResult  <= i_ex_alu_result;
            r_rd         <= i_ex_rd;
            r_rfWe       <= i_ex_rf_we;
            r_memOp      <= w_exIsMem ? i_ex_mem_op : MEM_OP_NONE;
            r_memSize    <= i_ex_mem_size;
            r_loadSigned <= i_ex_load_signed;
            r_storeData  <= i_ex_store_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (w_rdataCapture) begin
            r_rdata <= i_data_rdata;
        end
    end

    mem_load_ext u_load_ext (
        .i_rdata   (r_rdata),
        .i_addr_lo (r_aluResult[1:0]),
        .i_size    (r_memSize),
        .i_signed  (r_loadSigned),
        .o_result  (w_loadResult)
    );

    assign o_data_wr    = (r_memOp == MEM_OP_STORE);
    assign o_data_size  = r_memSize;
    assign o_data_addr  = r_aluResult;
    assign o_data_wstrb = o_data_wr ? calcWstrb(r_memSize, r_aluResult[1:0]) : 4'b0000;
    assign o_data_wdata = calcWdata(r_memSize, r_storeData);

    assign o_mem_pc     = r_pc;
    assign o_mem_rd     = r_rd;
    assign o_mem_rf_we  = r_rfWe;
    assign o_mem_result = w_isLoad ? w_loadResult : r_aluResult;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed corner cases followed by random
// transactions, with the SRAM side driven by the bench and a reference model.
module tb_mem_stage;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        sgn;
        logic [4:0]  rd;
        logic        rfWe;
        logic [31:0] pc;
        int          addrDelay;
        int          dataDelay;
        bit          sameCycle;
        int          stall;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        exValid;
    logic        memAllowin;
    logic [31:0] exPc;
    logic [31:0] exAlu;
    logic [4:0]  exRd;
    logic        exRfWe;
    logic [1:0]  exMemOp;
    logic [1:0]  exMemSize;
    logic        exSigned;
    logic [31:0] exStoreData;
    logic        dataReq;
    logic        dataWr;
    logic [1:0]  dataSize;
    logic [31:0] dataAddr;
    logic [3:0]  dataWstrb;
    logic [31:0] dataWdata;
    logic        addrOk;
    logic        dataOk;
    logic [31:0] rdata;
    logic        wbAllowin;
    logic        readyGo;
    logic [31:0] memPc;
    logic [4:0]  memRd;
    logic        memRfWe;
    logic [31:0] memResult;
    logic        fwdBusy;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .i_ex_to_mem_valid(exValid),
        .o_mem_allowin    (memAllowin),
        .i_ex_pc          (exPc),
        .i_ex_alu_result  (exAlu),
        .i_ex_rd          (exRd),
        .i_ex_rf_we       (exRfWe),
        .i_ex_mem_op      (exMemOp),
        .i_ex_mem_size    (exMemSize),
        .i_ex_load_signed (exSigned),
        .i_ex_store_data  (exStoreData),
        .o_data_req       (dataReq),
        .o_data_wr        (dataWr),
        .o_data_size      (dataSize),
        .o_data_addr      (dataAddr),
        .o_data_wstrb     (dataWstrb),
        .o_data_wdata     (dataWdata),
        .i_data_addr_ok   (addrOk),
        .i_data_data_ok   (dataOk),
        .i_data_rdata     (rdata),
        .i_wb_allowin     (wbAllowin),
        .o_mem_ready_go   (readyGo),
        .o_mem_pc         (memPc),
        .o_mem_rd         (memRd),
        .o_mem_rf_we      (memRfWe),
        .o_mem_result     (memResult),
        .o_mem_fwd_busy   (fwdBusy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    // Reference model: pick the addressed lane by plain division, then extend.
    function automatic logic [31:0] expLoad(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic sgn);
        int unsigned w;
        int unsigned v;
        int          bits;
        w = word;
        if (size == 2'd0) begin
            bits = 8;
            v = (w / (32'd1 << (8 * off))) % 256;
        end else if (size == 2'd1) begin
            bits = 16;
            v = (w / (32'd1 << (16 * off[1]))) % 65536;
        end else begin
            return word;
        end
        if (sgn && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    function automatic logic [3:0] expWstrb(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd0) return 4'(1 << off);
        if (size == 2'd1) return 4'(3 << (2 * off[1]));
        return 4'hF;
    endfunction

    function automatic logic [31:0] expWdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (size == 2'd1) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic txn_t makeTxn(input logic [1:0] op, input logic [1:0] size, input logic [31:0] addr,
                                     input logic [31:0] sdata, input logic [31:0] rd32, input logic sgn,
                                     input logic [4:0] rd, input int addrDelay, input bit sameCycle,
                                     input int stall);
        txn_t t;
        t.op = op; t.size = size; t.addr = addr; t.sdata = sdata; t.rdata = rd32; t.sgn = sgn;
        t.rd = rd; t.rfWe = 1'b1; t.pc = 32'h1C00_0000 + {27'h0, rd} * 4;
        t.addrDelay = addrDelay; t.dataDelay = 1; t.sameCycle = sameCycle; t.stall = stall;
        return t;
    endfunction

    function automatic txn_t randomTxn();
        txn_t t;
        t.op = 2'($urandom_range(0, 3));
        t.size = 2'($urandom_range(0, 2));
        t.addr = $urandom;
        if (t.size == 2'd1) t.addr[0] = 1'b0;
        if (t.size == 2'd2) t.addr[1:0] = 2'b00;
        t.sdata = $urandom;
        t.rdata = $urandom;
        t.sgn = 1'($urandom_range(0, 1));
        t.rd = 5'($urandom_range(0, 31));
        t.rfWe = 1'($urandom_range(0, 1));
        t.pc = $urandom;
        t.addrDelay = $urandom_range(0, 3);
        t.dataDelay = $urandom_range(0, 3);
        t.sameCycle = ($urandom_range(0, 3) == 0);
        t.stall = $urandom_range(0, 3);
        return t;
    endfunction

    task automatic scrambleEx();
        exValid = 1'($urandom_range(0, 1));
        exPc = $urandom; exAlu = $urandom; exRd = 5'($urandom_range(0, 31));
        exRfWe = 1'($urandom_range(0, 1)); exMemOp = 2'($urandom_range(0, 3));
        exMemSize = 2'($urandom_range(0, 2)); exSigned = 1'($urandom_range(0, 1));
        exStoreData = $urandom;
    endtask

    task automatic driveEx(input txn_t t);
        exValid = 1'b1; exPc = t.pc; exAlu = t.addr; exRd = t.rd; exRfWe = t.rfWe;
        exMemOp = t.op; exMemSize = t.size; exSigned = t.sgn; exStoreData = t.sdata;
        wbAllowin = 1'b1;
        #1;
        checkOutput("allowin_at_capture", 32'(memAllowin), 32'd1);
        stepCycle;
        wbAllowin = 1'b0;
        scrambleEx();
    endtask

    // One full instruction: capture, SRAM handshake, DONE hold with optional WB stall.
    task automatic applyStimulus(input txn_t t);
        logic        isLoad;
        logic        isStore;
        logic [31:0] expRes;
        isLoad  = (t.op == 2'b01);
        isStore = (t.op == 2'b10);
        expRes  = isLoad ? expLoad(t.rdata, t.addr[1:0], t.size, t.sgn) : t.addr;
        driveEx(t);
        #1;
        if (isLoad || isStore) begin
            checkOutput("req_asserted", 32'(dataReq), 32'd1);
            checkOutput("req_wr", 32'(dataWr), 32'(isStore));
            checkOutput("req_addr", dataAddr, t.addr);
            checkOutput("req_size", 32'(dataSize), 32'(t.size));
            checkOutput("req_wstrb", 32'(dataWstrb), isStore ? 32'(expWstrb(t.size, t.addr[1:0])) : 32'd0);
            if (isStore) checkOutput("req_wdata", dataWdata, expWdata(t.size, t.sdata));
            checkOutput("req_fwd_busy", 32'(fwdBusy), 32'(isLoad && t.rfWe));
            checkOutput("req_not_ready", 32'(readyGo), 32'd0);
            for (int i = 0; i < t.addrDelay; i++) begin
                stepCycle;
                checkOutput("req_held", 32'(dataReq), 32'd1);
                checkOutput("req_addr_held", dataAddr, t.addr);
                if (isStore) checkOutput("req_wdata_held", dataWdata, expWdata(t.size, t.sdata));
            end
            addrOk = 1'b1;
            if (t.sameCycle) begin
                dataOk = 1'b1;
                rdata  = t.rdata;
            end
            stepCycle;
            addrOk = 1'b0; dataOk = 1'b0; rdata = $urandom;
            if (!t.sameCycle) begin
                #1;
                checkOutput("wait_no_req", 32'(dataReq), 32'd0);
                checkOutput("wait_not_ready", 32'(readyGo), 32'd0);
                checkOutput("wait_fwd_busy", 32'(fwdBusy), 32'(isLoad && t.rfWe));
                for (int i = 0; i < t.dataDelay; i++) stepCycle;
                dataOk = 1'b1;
                rdata  = t.rdata;
                stepCycle;
                dataOk = 1'b0; rdata = $urandom;
            end
        end
        #1;
        checkOutput("done_ready", 32'(readyGo), 32'd1);
        checkOutput("done_result", memResult, expRes);
        checkOutput("done_pc", memPc, t.pc);
        checkOutput("done_rd", 32'(memRd), 32'(t.rd));
        checkOutput("done_rf_we", 32'(memRfWe), 32'(t.rfWe));
        checkOutput("done_no_req", 32'(dataReq), 32'd0);
        checkOutput("done_fwd_idle", 32'(fwdBusy), 32'd0);
        checkOutput("done_allowin_blocked", 32'(memAllowin), 32'd0);
        for (int i = 0; i < t.stall; i++) begin
            dataOk = 1'($urandom_range(0, 1));
            rdata  = $urandom;
            stepCycle;
            checkOutput("stall_ready", 32'(readyGo), 32'd1);
            checkOutput("stall_result", memResult, expRes);
            checkOutput("stall_pc", memPc, t.pc);
            checkOutput("stall_allowin", 32'(memAllowin), 32'd0);
        end
        dataOk = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_ready", 32'(readyGo), 32'd0);
        checkOutput("rst_allowin", 32'(memAllowin), 32'd1);
        checkOutput("rst_req", 32'(dataReq), 32'd0);
        checkOutput("rst_wr", 32'(dataWr), 32'd0);
        checkOutput("rst_pc", memPc, 32'd0);
        checkOutput("rst_rd", 32'(memRd), 32'd0);
        checkOutput("rst_rf_we", 32'(memRfWe), 32'd0);
        checkOutput("rst_result", memResult, 32'd0);
        checkOutput("rst_addr", dataAddr, 32'd0);
        checkOutput("rst_wstrb", 32'(dataWstrb), 32'd0);
        checkOutput("rst_wdata", dataWdata, 32'd0);
        checkOutput("rst_fwd", 32'(fwdBusy), 32'd0);
    endtask

    task automatic goIdle();
        exValid = 1'b0;
        wbAllowin = 1'b1;
        stepCycle;
        wbAllowin = 1'b0;
        #1;
        checkOutput("idle_ready", 32'(readyGo), 32'd0);
        checkOutput("idle_allowin", 32'(memAllowin), 32'd1);
    endtask

    // Start a load, reset it in REQ or WAIT, then feed stray data_ok pulses.
    task automatic resetMidTxn(input bit inWait);
        txn_t t;
        t = makeTxn(2'b01, 2'b10, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 1'b0, 5'd9, 0, 1'b0, 0);
        driveEx(t);
        exValid = 1'b0;
        #1;
        checkOutput("mid_req_up", 32'(dataReq), 32'd1);
        if (inWait) begin
            addrOk = 1'b1;
            stepCycle;
            addrOk = 1'b0;
            #1;
            checkOutput("mid_wait_fwd", 32'(fwdBusy), 32'd1);
        end
        rst = 1'b1;
        #1;
        checkOutput("rst_drops_req", 32'(dataReq), 32'd0);
        stepCycle;
        rst = 1'b0;
        #1;
        checkResetState();
        for (int i = 0; i < 3; i++) begin
            dataOk = 1'b1;
            rdata  = $urandom;
            stepCycle;
            checkOutput("stray_ready", 32'(readyGo), 32'd0);
            checkOutput("stray_req", 32'(dataReq), 32'd0);
            checkOutput("stray_allowin", 32'(memAllowin), 32'd1);
        end
        dataOk = 1'b0;
    endtask

    initial begin
        txn_t t;
        int   r;
        rst = 1'b1; exValid = 1'b0; exPc = 0; exAlu = 0; exRd = 0; exRfWe = 0;
        exMemOp = 0; exMemSize = 0; exSigned = 0; exStoreData = 0;
        addrOk = 1'b0; dataOk = 1'b0; rdata = 0; wbAllowin = 1'b0;
        stepCycle;
        stepCycle;
        rst = 1'b0;
        #1;
        checkResetState();

        $display("[TB] directed cases");
        applyStimulus(makeTxn(2'b00, 2'b10, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 5'd5, 0, 1'b0, 0));
        applyStimulus(makeTxn(2'b01, 2'b00, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 1'b1, 5'd6, 1, 1'b0, 0));
        applyStimulus(makeTxn(2'b01, 2'b00, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 1'b0, 5'd7, 0, 1'b0, 0));
        applyStimulus(makeTxn(2'b10, 2'b01, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1'b0, 5'd0, 3, 1'b0, 0));
        applyStimulus(makeTxn(2'b01, 2'b01, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 1'b1, 5'd8, 0, 1'b1, 4));
        applyStimulus(makeTxn(2'b11, 2'b00, 32'h0000_5678, 32'h0, 32'h0, 1'b0, 5'd10, 0, 1'b0, 1));
        goIdle();
        resetMidTxn(1'b1);
        resetMidTxn(1'b0);

        $display("[TB] random cases");
        for (int n = 0; n < 300; n++) begin
            t = randomTxn();
            applyStimulus(t);
            r = $urandom_range(0, 9);
            if (r == 0) goIdle();
            else if (r == 1) resetMidTxn(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
